// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin sharing of one multi-cycle FPU (single op in flight) among NREQ requesters.
// Optional watchdog abort of stuck ops is enabled by defining FPU_ARB_TIMEOUT_EN.
module fpu_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [4*NREQ-1:0]  req_ctl,
    input  logic [32*NREQ-1:0] req_x1,
    input  logic [32*NREQ-1:0] req_x2,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [31:0]        rsp_y,
    output logic               rsp_err,
    output logic               busy,
    output logic               fpu_en,
    output logic [3:0]         fpu_ctl,
    output logic [31:0]        fpu_x1,
    output logic [31:0]        fpu_x2,
    input  logic               fpu_ready,
    input  logic [31:0]        fpu_y
);
    // state | meaning
    // IDLE  | no op in flight; a grant is sampled at every edge
    // WAIT  | op issued; ctl/operands held until fpu_ready (or watchdog expiry)
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   owner, owner_nxt;
    logic [IW-1:0]   rr_last, rr_last_nxt;
    logic [IW-1:0]   winner;
    logic            found;
    logic [NREQ-1:0] req_ready_nxt, rsp_valid_nxt;
    logic [31:0]     rsp_y_nxt, fpu_x1_nxt, fpu_x2_nxt;
    logic [3:0]      fpu_ctl_nxt;
    logic            fpu_en_nxt;
    logic [3:0]      ctl_arr [NREQ];
    logic [31:0]     x1_arr  [NREQ];
    logic [31:0]     x2_arr  [NREQ];

`ifdef FPU_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt, wait_cnt_nxt;
    logic          rsp_err_nxt;
`endif

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign ctl_arr[i] = req_ctl[4*i +: 4];
        assign x1_arr[i]  = req_x1[32*i +: 32];
        assign x2_arr[i]  = req_x2[32*i +: 32];
    end

    // Search starts just after the last winner, wrapping modulo NREQ.
    always_comb begin : pick
        logic [IW-1:0] cand;
        found  = 1'b0;
        winner = rr_last;
        cand   = rr_last;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(rr_last) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        rr_last_nxt   = rr_last;
        req_ready_nxt = '0;
        rsp_valid_nxt = '0;
        fpu_en_nxt    = 1'b0;
        fpu_ctl_nxt   = fpu_ctl;
        fpu_x1_nxt    = fpu_x1;
        fpu_x2_nxt    = fpu_x2;
        rsp_y_nxt     = rsp_y;
`ifdef FPU_ARB_TIMEOUT_EN
        wait_cnt_nxt  = wait_cnt;
        rsp_err_nxt   = rsp_err;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    fpu_ctl_nxt           = ctl_arr[winner];
                    fpu_x1_nxt            = x1_arr[winner];
                    fpu_x2_nxt            = x2_arr[winner];
                    fpu_en_nxt            = 1'b1;
                    req_ready_nxt[winner] = 1'b1;
                    owner_nxt             = winner;
                    rr_last_nxt           = winner;
                    state_nxt             = WAIT;
`ifdef FPU_ARB_TIMEOUT_EN
                    wait_cnt_nxt          = '0;
`endif
                end
            end
            WAIT: begin
                if (fpu_ready) begin
                    rsp_y_nxt            = fpu_y;
                    rsp_valid_nxt[owner] = 1'b1;
                    state_nxt            = IDLE;
`ifdef FPU_ARB_TIMEOUT_EN
                    rsp_err_nxt          = 1'b0;
`endif
                end
`ifdef FPU_ARB_TIMEOUT_EN
                else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                    rsp_y_nxt            = '0;
                    rsp_valid_nxt[owner] = 1'b1;
                    rsp_err_nxt          = 1'b1;
                    state_nxt            = IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt + CW'(1);
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            owner     <= '0;
            rr_last   <= IW'(NREQ - 1);
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_y     <= '0;
            fpu_en    <= 1'b0;
            fpu_ctl   <= '0;
            fpu_x1    <= '0;
            fpu_x2    <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            rr_last   <= rr_last_nxt;
            req_ready <= req_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_y     <= rsp_y_nxt;
            fpu_en    <= fpu_en_nxt;
            fpu_ctl   <= fpu_ctl_nxt;
            fpu_x1    <= fpu_x1_nxt;
            fpu_x2    <= fpu_x2_nxt;
        end
    end

`ifdef FPU_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wait_cnt <= '0;
            rsp_err  <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
            rsp_err  <= rsp_err_nxt;
        end
    end
`else
    // Without the watchdog nothing can abort, so rsp_err is constant 0 (TIMEOUT has no effect).
    assign rsp_err = (TIMEOUT < 0);
`endif

    assign busy = (state != IDLE);

endmodule
